spawn_position_gen: RTL and testbench
=====================================

// Module: spawn_position_gen
// PURPOSE
//  Picks the ordinal of the empty cell that receives the next spawned tile.
//  Sits directly upstream of the new-tile stage: on each request it snapshots the
//  4x4 board, counts empty (==0) cells, then reduces a pseudo-random byte modulo
//  that count. Its position/valid outputs feed the new-tile position/enable inputs.
//  It also flags a full board so game-over logic can react.
// PARAMETERS
//  SEED   16'hACE1  LFSR reset value; 0 is illegal and is replaced by 16'hACE1
// PORTS
//  clk        in   1            system clock, all state on posedge
//  rst_n      in   1            asynchronous, active-low reset
//  req        in   1            start a pick; sampled only in IDLE
//  matrix     in   12 [3:0][3:0] board, cell value 0 = empty
//  busy       out  1            high in COUNT/REDUCE/DONE
//  valid      out  1            one-cycle pulse: position/full are valid
//  position   out  4            ordinal among empty cells, row-major i then j
//  full       out  1            no empty cell found (position forced 0)
//  seed_load  in   1            [SEED_LOAD_EN only] reload LFSR
//  seed_in    in   16           [SEED_LOAD_EN only] value for reload
// BEHAVIOUR
//  Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
//  Reset: state=IDLE, busy=0, valid=0, position=0, full=0, LFSR=SEED, counters 0.
//  LFSR: 16-bit Galois, mask 16'hB400, shifts right every cycle in every state.
//   Never reaches 0.
//  FSM IDLE->COUNT->REDUCE->DONE->IDLE; req in IDLE at edge T:
//   - snap<=matrix, rnd<=LFSR[7:0], cnt<=0, idx<=0, goto COUNT.
//  COUNT (cycles T+1..T+16): one cell per cycle.
//   - idx 0..15 maps to row i=idx[3:2] and column j=idx[1:0].
//   - cnt (5-bit) increments when snap cell==0.
//   - After idx 15: if the final count is 0, goto DONE with full=1. Else goto REDUCE.
//  REDUCE: each cycle, if rnd>=cnt then rnd<=rnd-cnt and stay. Else goto DONE.
//   - k=floor(rnd/cnt) subtractions, so REDUCE lasts k+1 cycles.
//  DONE: valid=1 for exactly one cycle.
//   - position=rnd[3:0]; rnd<cnt<=16, so it always fits.
//   - Then goto IDLE. position/full hold until the next pick's DONE.
//  Latency req->valid: T+17 if the board is full, else T+18+k.
//  req outside IDLE: ignored, no queuing. req held high restarts right after DONE.
//  matrix changes after T: no effect (snapshot). Only req in IDLE re-snapshots.
//  Ordinal semantics match the new-tile stage: the n-th zero cell in row-major order.
//  rst_n low in any state: immediate return to reset values, pick aborted, no valid.
// CONFIGURATION
//  SEED_LOAD_EN defined:
//   - Adds seed_load/seed_in.
//   - seed_load=1 at an edge sets LFSR<=seed_in (0 -> 16'hACE1), overriding the shift.
//   - Allowed in any state; rnd already captured is unaffected.
//   - A req on the edge after the load captures rnd=seed_in[7:0].
//  SEED_LOAD_EN undefined: ports absent; LFSR is set only by reset/SEED.
// TESTING
//  1 SEED_LOAD_EN, seed_in=16'h0025, all 16 cells 0, req next edge:
//    cnt=16, k=2 -> position=5, full=0, valid at T+20.
//  2 seed_in=16'h00C8 (rnd=200), only cell [2][1] zero:
//    cnt=1 -> position=0, valid at T+218, busy high T+1..T+218.
//  3 No zero cells, any seed -> valid at T+17 with full=1, position=0, one-cycle pulse.
//  4 rnd=7, cells 0..7 zero, req pulsed again at T+5 and matrix zeroed at T+3:
//    second req ignored; cnt=8 (snapshot) -> position=7 at T+18.
//  5 rst_n low in REDUCE of test 2 -> busy/valid/position/full=0 at once.
//    A later req after release completes normally.
//  6 No macro, SEED default, 100 random boards with >=1 zero:
//    position<cnt every pick; sequence matches the golden LFSR model exactly.

Source files
------------

// File: rtl/spawn_position_gen.sv
// Spawn-position picker: snapshots the 4x4 board, counts empty cells, reduces an
// LFSR byte modulo that count. Optional macro SEED_LOAD_EN adds a runtime LFSR reload.
module spawn_position_gen #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic [3:0][3:0][11:0]  matrix,
`ifdef SEED_LOAD_EN
  input  logic                   seed_load,
  input  logic [15:0]            seed_in,
`endif
  output logic                   busy,
  output logic                   valid,
  output logic [3:0]             position,
  output logic                   full
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  typedef enum logic [1:0] {IDLE, COUNT, REDUCE, DONE} state_e;

  state_e                 state_q, state_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [3:0][3:0][11:0]  snap_q;
  logic [7:0]             rnd_q;
  logic [4:0]             cnt_q;
  logic [3:0]             idx_q;
  logic [3:0]             pos_q;
  logic                   full_q;

  logic                   cell_zero;
  logic [4:0]             cnt_inc;
  logic                   rnd_ge;

  assign cell_zero = (snap_q[idx_q[3:2]][idx_q[1:0]] == 12'd0);
  assign cnt_inc   = cnt_q + {4'd0, cell_zero};
  assign rnd_ge    = (rnd_q >= {3'b000, cnt_q});

  // Galois step every cycle; a load replaces the step, zero seed is remapped
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
`ifdef SEED_LOAD_EN
    if (seed_load) lfsr_d = (seed_in == 16'h0000) ? 16'hACE1 : seed_in;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = COUNT;
      COUNT:   if (idx_q == 4'd15) state_d = (cnt_inc == 5'd0) ? DONE : REDUCE;
      REDUCE:  if (!rnd_ge) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    valid    = (state_q == DONE);
    position = pos_q;
    full     = full_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED_EFF;
      snap_q <= '0;
      rnd_q  <= 8'd0;
      cnt_q  <= 5'd0;
      idx_q  <= 4'd0;
      pos_q  <= 4'd0;
      full_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      unique case (state_q)
        IDLE: if (req) begin
          snap_q <= matrix;
          rnd_q  <= lfsr_q[7:0];
          cnt_q  <= 5'd0;
          idx_q  <= 4'd0;
        end
        COUNT: begin
          cnt_q <= cnt_inc;
          idx_q <= idx_q + 4'd1;
          if (idx_q == 4'd15 && cnt_inc == 5'd0) begin
            pos_q  <= 4'd0;
            full_q <= 1'b1;
          end
        end
        // Modulo by repeated subtraction; remainder < cnt <= 16 fits in 4 bits
        REDUCE: begin
          if (rnd_ge) rnd_q <= rnd_q - {3'b000, cnt_q};
          else begin
            pos_q  <= rnd_q[3:0];
            full_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spawn_position_gen.sv
// Scoreboard bench for spawn_position_gen (default build): a reference model predicts
// each pick's position/full/latency from the LFSR sequence and integer division.
module tb_spawn_position_gen;

  typedef logic [3:0][3:0][11:0] board_t;
  typedef struct {
    int pos;
    int full;
    int due;
    int cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  board_t      matrix = '0;
  logic        busy, valid, full;
  logic [3:0]  position;

  int total = 0;
  int bad   = 0;

  exp_t        q[$];
  logic [15:0] m_lfsr = 16'hACE1;
  int          cyc = 0;
  int          free_at = 0;
  int          t_acc = -100;
  int          due_last = -100;
  int          last_pos = 0;
  int          last_full = 0;

  spawn_position_gen dut (
    .clk(clk), .rst_n(rst_n), .req(req), .matrix(matrix),
    .busy(busy), .valid(valid), .position(position), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // Reference model: a pick accepted at edge T ends with valid sampled at edge due
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_lfsr = 16'hACE1; q.delete(); free_at = 0;
      t_acc = -100; due_last = -100; last_pos = 0; last_full = 0;
    end else begin
      if (req && cyc >= free_at) begin
        exp_t e;
        int rnd, n;
        rnd = int'(m_lfsr[7:0]);
        n = 0;
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            if (matrix[i][j] == 12'd0) n++;
        e.cnt = n;
        if (n == 0) begin
          e.pos = 0; e.full = 1; e.due = cyc + 17;
        end else begin
          e.pos = rnd % n; e.full = 0; e.due = cyc + 18 + rnd / n;
        end
        q.push_back(e);
        t_acc = cyc; due_last = e.due; free_at = e.due + 1;
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  // Monitor: pops on valid, otherwise checks that outputs hold and busy tracks the pick
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (valid) begin
        if (q.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("position", int'(position), e.pos);
          chk("full", int'(full), e.full);
          chk("latency_edge", cyc + 1, e.due);
          if (e.full == 0) chk("pos_lt_cnt", int'(int'(position) < e.cnt), 1);
          last_pos = e.pos; last_full = e.full;
        end
      end else begin
        chk("hold_position", int'(position), last_pos);
        chk("hold_full", int'(full), last_full);
      end
      chk("busy", int'(busy), int'(cyc >= t_acc && cyc <= due_last - 1));
    end
  end

  function automatic board_t rand_board(input int pct_zero, input bit force_zero);
    board_t b;
    bit any;
    any = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(99) < pct_zero) begin b[i][j] = 12'd0; any = 1; end
        else b[i][j] = 12'($urandom_range(4095, 1));
      end
    if (force_zero && !any) b[$urandom_range(3)][$urandom_range(3)] = 12'd0;
    return b;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 2000) begin
      @(posedge clk); n++;
    end
    #2;
    if (n >= 2000) chk("timeout_wait_idle", 1, 0);
  endtask

  task automatic pick(input board_t b);
    @(posedge clk); #2;
    matrix = b; req = 1'b1;
    @(posedge clk); #2;
    req = 1'b0;
    wait_idle();
  endtask

  initial begin
    board_t b;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_position", int'(position), 0);
    chk("rst_full", int'(full), 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // full board, all-empty board, single empty cell [2][1]
    pick(rand_board(0, 0));
    pick('0);
    b = rand_board(0, 0); b[2][1] = 12'd0;
    pick(b);

    // snapshot: matrix change at T+3 and a second req at T+5 have no effect
    b = '1;
    for (int k = 0; k < 8; k++) b[k / 4][k % 4] = 12'd0;
    @(posedge clk); #2 matrix = b; req = 1'b1;
    @(posedge clk); #2 req = 1'b0;
    repeat (2) @(posedge clk);
    #2 matrix = '0;
    repeat (2) @(posedge clk);
    #2 req = 1'b1;
    @(posedge clk); #2 req = 1'b0;
    wait_idle();

    // reset in the middle of a pick
    b = rand_board(0, 0); b[0][3] = 12'd0;
    @(posedge clk); #2 matrix = b; req = 1'b1;
    @(posedge clk); #2 req = 1'b0;
    repeat (25) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_position", int'(position), 0);
    chk("midrst_full", int'(full), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    pick(rand_board(40, 1));

    // req held high: picks restart back to back
    @(posedge clk); #2 matrix = rand_board(50, 1); req = 1'b1;
    repeat (80) @(posedge clk);
    #2 req = 1'b0;
    wait_idle();

    // random boards, each with at least one empty cell
    for (int n = 0; n < 100; n++) begin
      pick(rand_board($urandom_range(100, 5), 1));
      repeat ($urandom_range(3)) @(posedge clk);
    end
    pick(rand_board(0, 0));

    wait_idle();
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
